// File: rtl/memory_write_ctrl.sv
// Write-side linked-list controller: chains ingress beats into free blocks and emits one descriptor per packet.
// Optional build macro MEM_WRITE_CTRL_STATS_EN adds packet/block statistics outputs.
module memory_write_ctrl #(
  parameter int BLOCK_BITS = 512,
  parameter int ADDR_W     = 12,
  parameter int PAYLOAD_W  = BLOCK_BITS - 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [PAYLOAD_W-1:0]  in_data_i,
  input  logic                  in_last_i,
  input  logic                  fl_valid_i,
  input  logic [ADDR_W-1:0]     fl_idx_i,
  output logic                  fl_pop_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_waddr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  output logic                  desc_valid_o,
  input  logic                  desc_ready_i,
  output logic [ADDR_W-1:0]     desc_addr_o,
  output logic [ADDR_W:0]       desc_nblocks_o
`ifdef MEM_WRITE_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_pkts_o,
  output logic [31:0]           stat_blocks_o
`endif
);

  typedef enum logic [1:0] {
    ALLOC,
    STREAM,
    DESC
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W:0]   cnt_q;
  logic              beat_acc;
  logic              desc_fire;
  logic [15:0]       footer;

  // A non-last beat needs a successor index in hand; gated by rst_n so the
  // combinational outputs also read zero while reset is held.
  assign in_ready_o   = rst_n & (state_q == STREAM) & (in_last_i | fl_valid_i);
  assign beat_acc     = in_valid_i & in_ready_o;
  assign desc_valid_o = (state_q == DESC);
  assign desc_fire    = desc_valid_o & desc_ready_i;

  // Footer: [15:4] next index, [3] eop, [2:0] reserved zero.
  assign footer = in_last_i ? {{ADDR_W{1'b0}}, 4'b1000} : {fl_idx_i, 4'b0000};

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can be inferred.
    state_d  = state_q;
    fl_pop_o = 1'b0;
    unique case (state_q)
      ALLOC: begin
        if (fl_valid_i) begin
          fl_pop_o = rst_n;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        fl_pop_o = beat_acc & ~in_last_i;
        if (beat_acc && in_last_i) state_d = DESC;
      end
      DESC: begin
        if (desc_ready_i) state_d = ALLOC;
      end
      default: state_d = ALLOC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ALLOC;
      head_q         <= '0;
      cur_q          <= '0;
      cnt_q          <= '0;
      mem_we_o       <= 1'b0;
      mem_waddr_o    <= '0;
      // NOTE: the wide write-data register is reset only because the output must read zero out of reset.
      mem_wdata_o    <= '0;
      desc_addr_o    <= '0;
      desc_nblocks_o <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so every register samples pre-edge values.
      state_q  <= state_d;
      mem_we_o <= beat_acc;
      if (state_q == ALLOC && fl_valid_i) begin
        head_q <= fl_idx_i;
        cur_q  <= fl_idx_i;
        cnt_q  <= '0;
      end
      if (beat_acc) begin
        mem_waddr_o <= cur_q;
        mem_wdata_o <= {in_data_i, footer};
        if (in_last_i) begin
          desc_addr_o    <= head_q;
          desc_nblocks_o <= cnt_q + 1'b1;
        end else begin
          cur_q <= fl_idx_i;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef MEM_WRITE_CTRL_STATS_EN
  // Blocks are counted on acceptance, so the count moves with the mem_we_o it produces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_o   <= '0;
      stat_blocks_o <= '0;
    end else begin
      if (desc_fire) stat_pkts_o   <= stat_pkts_o + 32'd1;
      if (beat_acc)  stat_blocks_o <= stat_blocks_o + 32'd1;
    end
  end
`endif

endmodule
